// File: rtl/tbird_tail_lights.sv
// tbird_tail_lights: Thunderbird-style sequential turn and hazard tail-light controller
module tbird_tail_lights #(
  parameter int TICK_DIV = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic right_button,
  input  logic left_button,
  input  logic hazard_button,
  output logic right_led1,
  output logic right_led2,
  output logic right_led3,
  output logic left_led1,
  output logic left_led2,
  output logic left_led3
);
  localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  typedef enum logic [2:0] {IDLE, R1, R2, R3, L1, L2, L3, HAZ} state_t;
  state_t state, next;
  logic [2:0] sync1, sync2;
  logic [W-1:0] count;
  logic tick, req_r, req_l, req_h;
  // requests are inverted before the synchronizer so a cleared flop reads as inactive
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ~{hazard_button, left_button, right_button};
      sync2 <= sync1;
    end
  end
  assign {req_h, req_l, req_r} = sync2;
  assign tick = count == LAST;
  // free-running prescaler producing one tick every TICK_DIV clocks
  always_ff @(posedge clock) begin
    if (!reset) count <= '0;
    else count <= tick ? '0 : count + 1'b1;
  end
  // state register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else state <= next;
  end
  // next-state: sweeps step once per tick, hazard pre-empts a sweep
  always_comb begin
    next = state;
    if (tick) begin
      case (state)
        IDLE:    next = (req_h || (req_l && req_r)) ? HAZ : req_l ? L1 : req_r ? R1 : IDLE;
        R1:      next = req_h ? HAZ : R2;
        R2:      next = req_h ? HAZ : R3;
        R3:      next = req_h ? HAZ : IDLE;
        L1:      next = req_h ? HAZ : L2;
        L2:      next = req_h ? HAZ : L3;
        L3:      next = req_h ? HAZ : IDLE;
        default: next = IDLE;
      endcase
    end
  end
  assign right_led1 = state inside {R1, R2, R3, HAZ};
  assign right_led2 = state inside {R2, R3, HAZ};
  assign right_led3 = state inside {R3, HAZ};
  assign left_led1  = state inside {L1, L2, L3, HAZ};
  assign left_led2  = state inside {L2, L3, HAZ};
  assign left_led3  = state inside {L3, HAZ};
endmodule

// File: tb/tb_tbird_tail_lights.sv
// tb_tbird_tail_lights: randomized and scripted checks of the tail-light controller against a behavioural model
module tb_tbird_tail_lights;
  localparam int TD = 8;
  logic clock = 0;
  logic reset = 0;
  logic right_button = 1, left_button = 1, hazard_button = 1;
  logic right_led1, right_led2, right_led3, left_led1, left_led2, left_led3;
  logic [5:0] leds;
  int checks = 0, fails = 0;
  int mode = 0, stp = 0, cnt = 0, cyc = 0;
  logic [2:0] p1 = '0, p2 = '0;

  tbird_tail_lights #(.TICK_DIV(TD)) dut (
    .clock(clock), .reset(reset),
    .right_button(right_button), .left_button(left_button), .hazard_button(hazard_button),
    .right_led1(right_led1), .right_led2(right_led2), .right_led3(right_led3),
    .left_led1(left_led1), .left_led2(left_led2), .left_led3(left_led3)
  );

  always #10 clock = ~clock;
  assign leds = {left_led3, left_led2, left_led1, right_led3, right_led2, right_led1};

  // mode: 0 idle, 1 right sweep, 2 left sweep, 3 hazard; stp = number of lit LEDs in a sweep
  function automatic logic [5:0] model_leds();
    logic [2:0] sweep;
    sweep = 3'((1 << stp) - 1);
    if (mode == 3) return 6'b111111;
    if (mode == 1) return {3'b000, sweep};
    if (mode == 2) return {sweep, 3'b000};
    return 6'b000000;
  endfunction

  task automatic step();
    logic h, l, r;
    @(posedge clock);
    cyc++;
    if (!reset) begin
      mode = 0; stp = 0; cnt = 0; p1 = '0; p2 = '0;
    end else begin
      {h, l, r} = p2;
      if (cnt == TD - 1) begin
        if (mode == 0) begin
          if (h || (l && r)) mode = 3;
          else if (l) begin mode = 2; stp = 1; end
          else if (r) begin mode = 1; stp = 1; end
        end else if (mode == 3) mode = 0;
        else if (h) mode = 3;
        else if (stp == 3) begin mode = 0; stp = 0; end
        else stp++;
        if (mode == 0 || mode == 3) stp = 0;
      end
      cnt = (cnt + 1) % TD;
      p2 = p1;
      p1 = ~{hazard_button, left_button, right_button};
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (6) begin
      {hazard_button, left_button, right_button} = 3'($urandom);
      step();
      checks++;
      if (leds !== 6'b0) begin fails++; $display("FAIL reset cyc=%0d leds=%b want=000000", cyc, leds); end
    end
    {hazard_button, left_button, right_button} = 3'b111;
    step();
    reset = 1;
  endtask

  task automatic test_idle();
    repeat (5) begin
      step();
      checks++;
      if (leds !== 6'b0) begin fails++; $display("FAIL idle cyc=%0d leds=%b want=000000", cyc, leds); end
    end
  endtask

  task automatic test_right();
    right_button = 0;
    repeat (50) begin
      step();
      checks++;
      if (leds !== model_leds()) begin fails++; $display("FAIL right_held cyc=%0d leds=%b want=%b", cyc, leds, model_leds()); end
    end
    right_button = 1;
    repeat (40) begin
      step();
      checks++;
      if (leds !== model_leds()) begin fails++; $display("FAIL right_release cyc=%0d leds=%b want=%b", cyc, leds, model_leds()); end
    end
    checks++;
    if (leds !== 6'b0) begin fails++; $display("FAIL right_settle leds=%b want=000000", leds); end
  endtask

  task automatic test_left();
    left_button = 0;
    repeat (50) begin
      step();
      checks++;
      if (leds !== model_leds()) begin fails++; $display("FAIL left_held cyc=%0d leds=%b want=%b", cyc, leds, model_leds()); end
    end
    left_button = 1;
    repeat (40) begin
      step();
      checks++;
      if (leds !== model_leds()) begin fails++; $display("FAIL left_release cyc=%0d leds=%b want=%b", cyc, leds, model_leds()); end
    end
  endtask

  task automatic test_hazard();
    hazard_button = 0;
    repeat (50) begin
      step();
      checks++;
      if (leds !== model_leds()) begin fails++; $display("FAIL hazard cyc=%0d leds=%b want=%b", cyc, leds, model_leds()); end
    end
    hazard_button = 1;
    repeat (30) begin
      step();
      checks++;
      if (leds !== model_leds()) begin fails++; $display("FAIL hazard_release cyc=%0d leds=%b want=%b", cyc, leds, model_leds()); end
    end
  endtask

  task automatic test_preempt();
    logic seen;
    seen = 0;
    right_button = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      checks++;
      if (leds !== model_leds()) begin fails++; $display("FAIL preempt_sweep cyc=%0d leds=%b want=%b", cyc, leds, model_leds()); end
      seen = right_led2;
    end
    checks++;
    if (!seen) begin fails++; $display("FAIL preempt_start right_led2=%b want=1", right_led2); end
    hazard_button = 0;
    repeat (TD + 2) begin
      step();
      checks++;
      if (leds !== model_leds()) begin fails++; $display("FAIL preempt cyc=%0d leds=%b want=%b", cyc, leds, model_leds()); end
      if (leds == 6'b111111) break;
    end
    checks++;
    if (leds !== 6'b111111) begin fails++; $display("FAIL preempt_allon leds=%b want=111111", leds); end
    {hazard_button, right_button} = 2'b11;
    repeat (40) begin
      step();
      checks++;
      if (leds !== model_leds()) begin fails++; $display("FAIL preempt_release cyc=%0d leds=%b want=%b", cyc, leds, model_leds()); end
    end
  endtask

  task automatic test_reset_mid();
    right_button = 0;
    repeat (10) step();
    right_button = 1; hazard_button = 0;
    repeat (10) step();
    hazard_button = 1; left_button = 0;
    repeat (25) begin
      step();
      checks++;
      if (leds !== model_leds()) begin fails++; $display("FAIL mid_run cyc=%0d leds=%b want=%b", cyc, leds, model_leds()); end
    end
    reset = 0;
    repeat (25) begin
      step();
      checks++;
      if (leds !== 6'b0) begin fails++; $display("FAIL mid_reset cyc=%0d leds=%b want=000000", cyc, leds); end
    end
    left_button = 1;
    reset = 1;
    repeat (30) begin
      step();
      checks++;
      if (leds !== 6'b0) begin fails++; $display("FAIL mid_after cyc=%0d leds=%b want=000000", cyc, leds); end
    end
  endtask

  task automatic test_both();
    left_button = 0; right_button = 0;
    repeat (50) begin
      step();
      checks++;
      if (leds !== model_leds()) begin fails++; $display("FAIL both cyc=%0d leds=%b want=%b", cyc, leds, model_leds()); end
    end
    left_button = 1; right_button = 1;
    repeat (20) begin
      step();
      checks++;
      if (leds !== model_leds()) begin fails++; $display("FAIL both_release cyc=%0d leds=%b want=%b", cyc, leds, model_leds()); end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    repeat (3000) begin
      if (hold == 0) begin
        {hazard_button, left_button, right_button} = 3'($urandom) | ($urandom_range(0, 2) != 0 ? 3'b100 : 3'b000);
        hold = $urandom_range(1, 40);
      end
      hold--;
      reset = $urandom_range(0, 199) != 0;
      step();
      checks++;
      if (leds !== model_leds()) begin fails++; $display("FAIL random cyc=%0d leds=%b want=%b", cyc, leds, model_leds()); end
    end
    reset = 1;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_right();
    test_left();
    test_hazard();
    test_preempt();
    test_reset_mid();
    test_both();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
